// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial add/subtract engine.
// The master supplies operands and consumes results; the slave is the engine.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial A+B / A-B over one shared full adder, LSB first; result valid WIDTH cycles after accept.
// Input accepted only in IDLE; result held in DONE until out_ready, outputs frozen under backpressure.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             c_msb_in;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic             accept;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Subtract is A + ~B + 1: invert B on load and seed the carry with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      c_q      <= 1'b0;
      cnt      <= '0;
      c_msb_in <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b ^ {WIDTH{bus.sub}};
      c_q  <= bus.sub;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      s_sr <= {fa_s, s_sr[WIDTH-1:1]};
      c_q  <= fa_co;
      if (last) begin
        cnt      <= '0;
        c_msb_in <= c_q;
        sum_q    <= {fa_s, s_sr[WIDTH-1:1]};
        cout_q   <= fa_co;
        ovf_q    <= fa_co ^ c_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // In DONE the sum shift register and captured MSB carry must agree with the published result.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state == DONE) |-> ((sum_q == s_sr) && (ovf_q == (cout_q ^ c_msb_in))));

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboarded bench for serial_add_ctrl: directed vectors at WIDTH=8, then random soak at WIDTH=8 and 32.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  if8 ();
  serial_add_ctrl_if #(.WIDTH(32)) if32 ();

  serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_add_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   done8 = 1'b0;
  bit   done32 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: wide add of A and (possibly inverted) B; overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] mask;
    logic [31:0] am;
    logic [31:0] bb;
    logic [32:0] full;
    exp_t        e;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am     = a & mask;
    bb     = (s ? ~b : b) & mask;
    full   = {1'b0, am} + {1'b0, bb} + 33'(s);
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (am[w-1] == bb[w-1]) && (e.sum[w-1] != am[w-1]);
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o;
    return e;
  endfunction

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && if8.out_valid && if8.out_ready) begin
      if (q8.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL w8_unexpected_result: got sum %0h, expected no result", if8.sum);
      end else begin
        e = q8.pop_front();
        chk("w8_sum",  32'(if8.sum),  e.sum);
        chk("w8_cout", 32'(if8.cout), 32'(e.cout));
        chk("w8_ovf",  32'(if8.ovf),  32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && if32.out_valid && if32.out_ready) begin
      if (q32.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL w32_unexpected_result: got sum %0h, expected no result", if32.sum);
      end else begin
        e = q32.pop_front();
        chk("w32_sum",  if32.sum,      e.sum);
        chk("w32_cout", 32'(if32.cout), 32'(e.cout));
        chk("w32_ovf",  32'(if32.ovf),  32'(e.ovf));
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, output int acc);
    acc = -1;
    if8.a = a; if8.b = b; if8.sub = s; if8.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if8.in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    if8.in_valid = 1'b0;
    if (acc < 0) chk("w8_accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s, output int acc);
    acc = -1;
    if32.a = a; if32.b = b; if32.sub = s; if32.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if32.in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    if32.in_valid = 1'b0;
    if (acc < 0) chk("w32_accept_timeout", 32'd1, 32'd0);
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_valid8(output int n);
    n = 0;
    while (!if8.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] va[5]   = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80};
  logic [7:0] vb[5]   = '{8'h33, 8'h01, 8'h7F, 8'h20, 8'h01};
  logic       vs[5]   = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
  logic [7:0] vsum[5] = '{8'h8D, 8'h00, 8'hFE, 8'hF0, 8'h7F};
  logic       vc[5]   = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
  logic       vo[5]   = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};

  initial begin : stim
    int acc;
    int prev;
    int lat;
    int h;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.sub = 1'b0; if8.out_ready = 1'b0;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.sub = 1'b0; if32.out_ready = 1'b0;

    @(posedge clk); #1;
    chk("rst_in_ready",  32'(if8.in_ready),  32'd1);
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_sum",       32'(if8.sum),       32'd0);
    chk("rst_cout",      32'(if8.cout),      32'd0);
    chk("rst_ovf",       32'(if8.ovf),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors, back to back with out_ready high.
    if8.out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      q8.push_back(mk(32'(vsum[i]), vc[i], vo[i]));
      send8(va[i], vb[i], vs[i], acc);
      wait_valid8(lat);
      chk("latency", 32'(lat), 32'd8);
      if (i > 0) chk("accept_spacing", 32'(acc - prev), 32'd10);
      prev = acc;
    end
    @(posedge clk); #1;

    // Backpressure: hold DONE for 5 cycles while in_valid pulses.
    if8.out_ready = 1'b0;
    q8.push_back(mk(32'h8D, 1'b0, 1'b1));
    send8(8'h5A, 8'h33, 1'b0, acc);
    wait_valid8(lat);
    chk("bp_latency", 32'(lat), 32'd8);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if8.in_valid = ~if8.in_valid;
      chk("bp_out_valid", 32'(if8.out_valid), 32'd1);
      chk("bp_in_ready",  32'(if8.in_ready),  32'd0);
      chk("bp_sum",       32'(if8.sum),       32'h8D);
      chk("bp_cout",      32'(if8.cout),      32'd0);
      chk("bp_ovf",       32'(if8.ovf),       32'd1);
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    h = cyc + 1;
    q8.push_back(mk(32'hFE, 1'b0, 1'b1));
    send8(8'h7F, 8'h7F, 1'b0, acc);
    chk("bp_release_accept", 32'(acc), 32'(h + 1));
    wait_valid8(lat);
    chk("bp_release_latency", 32'(lat), 32'd8);
    @(posedge clk); #1;

    // Reset during the third RUN cycle discards the operation.
    send8(8'h11, 8'h22, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("midrun_rst_sum",       32'(if8.sum),       32'd0);
    chk("midrun_rst_ovf",       32'(if8.ovf),       32'd0);
    chk("midrun_rst_in_ready",  32'(if8.in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q8.push_back(mk(32'h03, 1'b0, 1'b0));
    send8(8'h01, 8'h02, 1'b0, acc);
    wait_valid8(lat);
    chk("post_rst_latency", 32'(lat), 32'd8);
    @(posedge clk); #1;

    // Random soak on both widths in parallel, then accept-spacing runs.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] ra;
          logic [7:0] rb;
          logic       rs;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
          q8.push_back(model(8, 32'(ra), 32'(rb), rs));
          send8(ra, rb, rs, acc);
        end
        done8 = 1'b1;
      end
      begin
        while (!done8) begin
          @(posedge clk); #1;
          if8.out_ready = 1'($urandom);
        end
        if8.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [31:0] ra;
          logic [31:0] rb;
          logic        rs;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          ra = $urandom; rb = $urandom; rs = 1'($urandom);
          q32.push_back(model(32, ra, rb, rs));
          send32(ra, rb, rs, acc);
        end
        done32 = 1'b1;
      end
      begin
        while (!done32) begin
          @(posedge clk); #1;
          if32.out_ready = 1'($urandom);
        end
        if32.out_ready = 1'b1;
      end
    join

    fork
      begin
        int p8;
        send8(8'h00, 8'h00, 1'b0, p8);
        q8.push_back(model(8, 32'h0, 32'h0, 1'b0));
        for (int i = 0; i < 10; i++) begin
          int a8;
          logic [7:0] ra;
          ra = 8'($urandom);
          q8.push_back(model(8, 32'(ra), 32'h5, 1'b1));
          send8(ra, 8'h05, 1'b1, a8);
          chk("w8_soak_spacing", 32'(a8 - p8), 32'd10);
          p8 = a8;
        end
      end
      begin
        int p32;
        send32(32'h0, 32'h0, 1'b0, p32);
        q32.push_back(model(32, 32'h0, 32'h0, 1'b0));
        for (int i = 0; i < 10; i++) begin
          int a32;
          logic [31:0] ra;
          ra = $urandom;
          q32.push_back(model(32, ra, 32'h8000_0001, 1'b0));
          send32(ra, 32'h8000_0001, 1'b0, a32);
          chk("w32_soak_spacing", 32'(a32 - p32), 32'd34);
          p32 = a32;
        end
      end
    join

    for (int i = 0; i < 200; i++) begin
      if (q8.size() == 0 && q32.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("w8_pending_results",  32'(q8.size()),  32'd0);
    chk("w32_pending_results", 32'(q32.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
